// File: rtl/score_scheduler.sv
// score_scheduler: round-robin scheduler for three hit sources feeding a
// digit-serial 4-digit BCD score adder, with saturation and high-score tracking.
module score_scheduler (
   input  logic       clk,
   input  logic       resetN,
   input  logic       monsterHit,
   input  logic       ufoHit,
   input  logic       bonusHit,
   input  logic       clearScore,
   input  logic       gameOver,
   output logic [3:0] scoreD0,
   output logic [3:0] scoreD1,
   output logic [3:0] scoreD2,
   output logic [3:0] scoreD3,
   output logic [3:0] hiD0,
   output logic [3:0] hiD1,
   output logic [3:0] hiD2,
   output logic [3:0] hiD3,
   output logic       busy,
   output logic       overflowErr
);
   // ADDn encodes the digit index in its low bits, which selects the digit being summed
   typedef enum logic [2:0] {ADD0 = 3'd0, ADD1 = 3'd1, ADD2 = 3'd2, ADD3 = 3'd3, IDLE = 3'd4} state_t;
   state_t           state_q, state_d;
   logic [2:0][3:0]  pend_q, pend_d;
   logic [15:0]      score_q, score_d, hi_q, hi_d, add_q, add_d;
   logic [1:0]       rr_q, rr_d, gidx, idx;
   logic [2:0]       hit, gnt, s;
   logic [3:0]       dig_pos, dres;
   logic [4:0]       dsum;
   logic             carry_q, carry_d, ovf_q, ovf_d, hs_q, hs_d;
   logic             any_pend, do_grant, game, dcarry;

   always_comb begin
      hit = {bonusHit, ufoHit, monsterHit} & {3{~clearScore}};
      game = gameOver & ~clearScore;
      any_pend = |pend_q;
      gidx = rr_q;
      s = '0;
      idx = '0;
      // scan from the farthest candidate back to rrPtr so the nearest nonzero one wins
      for (int k = 2; k >= 0; k--) begin
         s = {1'b0, rr_q} + 3'(k);
         idx = (s > 3'd2) ? 2'(s - 3'd3) : s[1:0];
         if (pend_q[idx] != 4'd0) gidx = idx;
      end
      do_grant = (state_q == IDLE) && any_pend && !clearScore;
      gnt = do_grant ? (3'b001 << gidx) : 3'b000;
      ovf_d = ovf_q;
      for (int i = 0; i < 3; i++) begin
         pend_d[i] = (hit[i] && !gnt[i]) ? ((pend_q[i] == 4'hF) ? pend_q[i] : pend_q[i] + 4'd1) :
                     (gnt[i] && !hit[i]) ? pend_q[i] - 4'd1 : pend_q[i];
         ovf_d = ovf_d | (hit[i] && !gnt[i] && pend_q[i] == 4'hF);
      end
      rr_d = do_grant ? ((gidx == 2'd2) ? 2'd0 : gidx + 2'd1) : rr_q;
      add_d = !do_grant ? add_q : (gidx == 2'd0) ? 16'h0005 : (gidx == 2'd1) ? 16'h0050 : 16'h0100;
      dig_pos = {state_q[1:0], 2'b00};
      dsum = {1'b0, score_q[dig_pos +: 4]} + {1'b0, add_q[dig_pos +: 4]} + {4'd0, carry_q};
      dcarry = dsum > 5'd9;
      dres = dcarry ? 4'(dsum - 5'd10) : dsum[3:0];
      state_d = state_q;
      score_d = score_q;
      hi_d = hi_q;
      carry_d = 1'b0;
      hs_d = hs_q | game;
      if (state_q == IDLE) begin
         state_d = do_grant ? ADD0 : IDLE;
         if (!any_pend && hs_q && !clearScore) begin
            hi_d = (score_q > hi_q) ? score_q : hi_q;
            hs_d = game;
         end
      end else begin
         score_d[dig_pos +: 4] = dres;
         carry_d = dcarry;
         state_d = (state_q == ADD3) ? IDLE : state_t'(state_q + 3'd1);
         if (state_q == ADD3 && dcarry) score_d = 16'h9999;
      end
      if (clearScore) begin
         state_d = IDLE;
         score_d = '0;
         pend_d = '0;
         ovf_d = 1'b0;
         hs_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= IDLE;
         pend_q  <= '0;
         score_q <= '0;
         hi_q    <= '0;
         add_q   <= '0;
         rr_q    <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         hs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         score_q <= score_d;
         hi_q    <= hi_d;
         add_q   <= add_d;
         rr_q    <= rr_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         hs_q    <= hs_d;
      end
   end

   assign {scoreD3, scoreD2, scoreD1, scoreD0} = score_q;
   assign {hiD3, hiD2, hiD1, hiD0} = hi_q;
   assign busy = state_q != IDLE;
   assign overflowErr = ovf_q;
endmodule

// File: tb/tb_score_scheduler.sv
// tb_score_scheduler: directed stimulus with a score scoreboard; the monitor
// pops an expected score every time busy falls (an add completes or is aborted).
module tb_score_scheduler;
   logic clk = 1'b0, resetN = 1'b0;
   logic monsterHit = 1'b0, ufoHit = 1'b0, bonusHit = 1'b0, clearScore = 1'b0, gameOver = 1'b0;
   logic [3:0] scoreD0, scoreD1, scoreD2, scoreD3, hiD0, hiD1, hiD2, hiD3;
   logic busy, overflowErr;
   logic [15:0] score, hi;
   logic [15:0] exp_q[$];
   logic prev_busy = 1'b0;
   int total = 0, bad = 0;

   score_scheduler dut (
      .clk(clk), .resetN(resetN), .monsterHit(monsterHit), .ufoHit(ufoHit), .bonusHit(bonusHit),
      .clearScore(clearScore), .gameOver(gameOver),
      .scoreD0(scoreD0), .scoreD1(scoreD1), .scoreD2(scoreD2), .scoreD3(scoreD3),
      .hiD0(hiD0), .hiD1(hiD1), .hiD2(hiD2), .hiD3(hiD3),
      .busy(busy), .overflowErr(overflowErr)
   );

   assign score = {scoreD3, scoreD2, scoreD1, scoreD0};
   assign hi = {hiD3, hiD2, hiD1, hiD0};

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (prev_busy && !busy) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_completion: score %h with nothing expected", score);
         end else check("score_event", {16'd0, score}, {16'd0, exp_q.pop_front()});
      end
      prev_busy = busy;
   end

   function automatic logic [15:0] bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic hit(input logic m, input logic u, input logic b);
      monsterHit = m;
      ufoHit = u;
      bonusHit = b;
      cyc();
      monsterHit = 1'b0;
      ufoHit = 1'b0;
      bonusHit = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      for (int i = 0; i < 300 && n < 2; i++) begin
         cyc();
         n = busy ? 0 : n + 1;
      end
      check("idle_reached", n >= 2, 1);
   endtask

   task automatic one(input logic m, input logic u, input logic b, input logic [15:0] e);
      exp_q.push_back(e);
      hit(m, u, b);
      wait_idle();
   endtask

   task automatic pulse_clear();
      clearScore = 1'b1;
      cyc();
      clearScore = 1'b0;
   endtask

   task automatic pulse_reset();
      resetN = 1'b0;
      cyc();
      resetN = 1'b1;
      cyc();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc();
      cyc();
      check("reset_score", score, 16'h0000);
      check("reset_hi", hi, 16'h0000);
      check("reset_flags", {busy, overflowErr}, 2'b00);
      resetN = 1'b1;
      cyc();
      // lone hit: busy for exactly four cycles, result after the fifth edge
      exp_q.push_back(16'h0005);
      hit(1'b1, 1'b0, 1'b0);
      check("busy_e0", busy, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         cyc();
         check("busy_add", busy, 1'b1);
      end
      cyc();
      check("busy_e5", busy, 1'b0);
      check("score_e5", score, 16'h0005);
      one(1'b1, 1'b0, 1'b0, 16'h0010);
      // simultaneous hits: order 0,1,2 at five-cycle spacing
      pulse_reset();
      exp_q.push_back(16'h0005);
      exp_q.push_back(16'h0055);
      exp_q.push_back(16'h0155);
      hit(1'b1, 1'b1, 1'b1);
      for (int i = 1; i <= 15; i++) begin
         cyc();
         check("rr_busy_pattern", busy, (i % 5) != 0);
      end
      cyc();
      check("rr_idle", busy, 1'b0);
      check("rr_score", score, 16'h0155);
      // pointer back at source 0: monster wins over ufo
      exp_q.push_back(16'h0160);
      exp_q.push_back(16'h0210);
      hit(1'b1, 1'b1, 1'b0);
      wait_idle();
      // preload 9950, then saturate
      pulse_reset();
      for (int i = 1; i <= 99; i++) one(1'b0, 1'b0, 1'b1, bcd(i * 100));
      one(1'b0, 1'b1, 1'b0, 16'h9950);
      one(1'b0, 1'b0, 1'b1, 16'h9999);
      one(1'b1, 1'b0, 1'b0, 16'h9999);
      // overflow: 20 back-to-back monster hits behind a ufo; 3 granted early, 15 queued, 2 dropped
      pulse_clear();
      check("clear_score", score, 16'h0000);
      exp_q.push_back(16'h0050);
      for (int k = 1; k <= 18; k++) exp_q.push_back(bcd(50 + 5 * k));
      hit(1'b0, 1'b1, 1'b0);
      monsterHit = 1'b1;
      repeat (20) cyc();
      monsterHit = 1'b0;
      check("ovf_set", overflowErr, 1'b1);
      wait_idle();
      check("ovf_score", score, 16'h0140);
      check("ovf_sticky", overflowErr, 1'b1);
      pulse_clear();
      check("ovf_cleared", overflowErr, 1'b0);
      // high score
      one(1'b0, 1'b0, 1'b1, 16'h0100);
      gameOver = 1'b1;
      cyc();
      gameOver = 1'b0;
      cyc();
      cyc();
      check("hi_first", hi, 16'h0100);
      pulse_clear();
      check("hi_after_clear", hi, 16'h0100);
      one(1'b0, 1'b1, 1'b0, 16'h0050);
      one(1'b0, 1'b1, 1'b0, 16'h0100);
      for (int k = 1; k <= 4; k++) one(1'b1, 1'b0, 1'b0, bcd(100 + 5 * k));
      exp_q.push_back(16'h0125);
      exp_q.push_back(16'h0130);
      monsterHit = 1'b1;
      cyc();
      cyc();
      monsterHit = 1'b0;
      gameOver = 1'b1;
      cyc();
      gameOver = 1'b0;
      repeat (5) cyc();
      check("hi_waits_for_hits", hi, 16'h0100);
      wait_idle();
      check("hi_updated", hi, 16'h0130);
      pulse_clear();
      check("hi_kept_on_clear", hi, 16'h0130);
      check("score_zero_on_clear", score, 16'h0000);
      gameOver = 1'b1;
      cyc();
      gameOver = 1'b0;
      cyc();
      cyc();
      check("hi_not_lowered", hi, 16'h0130);
      // clearScore during ADD1 aborts the add
      one(1'b0, 1'b1, 1'b0, 16'h0050);
      exp_q.push_back(16'h0000);
      hit(1'b1, 1'b0, 1'b0);
      cyc();
      cyc();
      check("partial_add0", score, 16'h0055);
      pulse_clear();
      check("abort_busy", busy, 1'b0);
      check("abort_score", score, 16'h0000);
      repeat (6) cyc();
      check("abort_no_late_busy", busy, 1'b0);
      check("abort_no_late_score", score, 16'h0000);
      // resetN during ADD1
      one(1'b0, 1'b1, 1'b0, 16'h0050);
      exp_q.push_back(16'h0000);
      hit(1'b1, 1'b0, 1'b0);
      cyc();
      cyc();
      #2 resetN = 1'b0;
      #1;
      check("async_rst_score", score, 16'h0000);
      check("async_rst_hi", hi, 16'h0000);
      check("async_rst_busy", busy, 1'b0);
      cyc();
      resetN = 1'b1;
      repeat (6) cyc();
      check("rst_no_late_busy", busy, 1'b0);
      check("rst_no_late_score", score, 16'h0000);
      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
